// File: rtl/alu_pkg.sv
// alu_seq shared types: opcodes, FSM state, flag vector.
// The ALU_MUL_EN macro selects whether opcode 111 runs the multiplier.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic {
    IDLE,
    MUL
  } alu_state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the control unit and alu_seq.
// The control unit drives the master side; alu_seq uses the slave side.
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [2:0]       ALU_Op;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             isZero;
  logic             carry;
  logic             negative;
  logic             overflow;

  modport master (
    output start, ALU_Op, inA, inB,
    input  busy, done, out, isZero,
    input  carry, negative, overflow
  );

  modport slave (
    input  start, ALU_Op, inA, inB,
    output busy, done, out, isZero,
    output carry, negative, overflow
  );

endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0]   mp_q, mp_d;
  logic [2*WIDTH-1:0] step;

  // prod_o is the accumulator after this edge's step, so the
  // caller can register the final product on the last edge
  assign step   = acc_q + (mp_q[0] ? mc_q : '0);
  assign prod_o = step;
  assign last_o = (cnt_q == CW'(1));

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    mc_d  = mc_q;
    mp_d  = mp_q;
    if (load_i) begin
      cnt_d = CW'(WIDTH);
      acc_d = '0;
      mc_d  = {{WIDTH{1'b0}}, a_i};
      mp_d  = b_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      acc_d = step;
      mc_d  = mc_q << 1;
      mp_d  = mp_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      mc_q  <= '0;
      mp_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mc_q  <= mc_d;
      mp_q  <= mp_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result and flags.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 111.
import alu_pkg::*;

module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] a, b, res;
  logic [2:0]       op;
  logic [SW-1:0]    amt;
  logic [WIDTH:0]   wide;
  logic             c, v;

  logic [WIDTH-1:0] out_q, out_d;
  alu_flags_t       flg_q, flg_d;
  logic             done_q, done_d;
  logic             c_d, v_d;

  assign a   = bus.inA;
  assign b   = bus.inB;
  assign op  = bus.ALU_Op;
  assign amt = b[SW-1:0];

  always_comb begin
    res  = '0;
    c    = 1'b0;
    v    = 1'b0;
    wide = '0;
    unique case (1'b1)
      (op == ALU_ADD): begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = (a[WIDTH-1] == b[WIDTH-1]) &&
               (res[WIDTH-1] != a[WIDTH-1]);
      end
      (op == ALU_SUB): begin
        wide = {1'b0, a} - {1'b0, b};
        res  = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = (a[WIDTH-1] != b[WIDTH-1]) &&
               (res[WIDTH-1] != a[WIDTH-1]);
      end
      (op == ALU_AND): res = a & b;
      (op == ALU_OR):  res = a | b;
      (op == ALU_XOR): res = a ^ b;
      // an extra bit on the shifted-out side catches the last bit lost
      (op == ALU_SHL): begin
        wide = {1'b0, a} << amt;
        res  = wide[WIDTH-1:0];
        c    = wide[WIDTH];
      end
      (op == ALU_SHR): begin
        wide = {a, 1'b0} >> amt;
        res  = wide[WIDTH:1];
        c    = wide[0];
      end
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  alu_state_t         state_q, state_d;
  logic               load;
  logic               last;
  logic [2*WIDTH-1:0] prod;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .a_i    (a),
    .b_i    (b),
    .last_o (last),
    .prod_o (prod)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    c_d     = flg_q.carry;
    v_d     = flg_q.overflow;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && op == ALU_MUL) begin
          load    = 1'b1;
          state_d = MUL;
        end else if (bus.start) begin
          out_d  = res;
          c_d    = c;
          v_d    = v;
          done_d = 1'b1;
        end
      end
      MUL: begin
        if (last) begin
          out_d   = prod[WIDTH-1:0];
          c_d     = |prod[2*WIDTH-1:WIDTH];
          v_d     = |prod[2*WIDTH-1:WIDTH];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign bus.busy = (state_q == MUL);
`else
  // opcode 111 falls through the decoder as an all-zero result
  always_comb begin
    out_d  = out_q;
    c_d    = flg_q.carry;
    v_d    = flg_q.overflow;
    done_d = 1'b0;
    if (bus.start) begin
      out_d  = res;
      c_d    = c;
      v_d    = v;
      done_d = 1'b1;
    end
  end

  assign bus.busy = 1'b0;
`endif

  always_comb begin
    flg_d          = flg_q;
    flg_d.zero     = ~|out_d;
    flg_d.carry    = c_d;
    flg_d.negative = out_d[WIDTH-1];
    flg_d.overflow = v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      flg_q  <= '{zero: 1'b1, default: 1'b0};
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      flg_q  <= flg_d;
      done_q <= done_d;
    end
  end

  assign bus.done     = done_q;
  assign bus.out      = out_q;
  assign bus.isZero   = flg_q.zero;
  assign bus.carry    = flg_q.carry;
  assign bus.negative = flg_q.negative;
  assign bus.overflow = flg_q.overflow;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked ALU for the RISC CPU datapath, succeeding the fixed 8-bit, 4-operation combinational ALU. It adds a start/busy/done protocol, registered results, a full flag set (zero, carry, negative, overflow), XOR and shift operations, and an optional iterative shift-add multiplier. The control unit issues one operation at a time and stalls on `busy`.

## Interface
- `WIDTH`, 8: operand and result width; legal range 4..32.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only while idle (`busy`=0).
- `ALU_Op`  in  3: operation code, captured with `start`.
- `inA`  in  WIDTH: operand A, captured with `start`.
- `inB`  in  WIDTH: operand B, captured with `start`.
- `busy`  out  1: multi-cycle operation in progress.
- `done`  out  1: one-cycle pulse; result and flags updated this cycle.
- `out`  out  WIDTH: registered result, held until the next `done`.
- `isZero`  out  1: `out` == 0.
- `carry`  out  1: carry, borrow, shifted-out bit, or multiply overflow.
- `negative`  out  1: `out[WIDTH-1]`.
- `overflow`  out  1: signed overflow.

## Operation
- Reset values: `busy`=0, `done`=0, `out`=0, `isZero`=1, `carry`=0, `negative`=0, `overflow`=0. FSM in IDLE, multiplier counter 0.
- FSM states: IDLE and MUL.
  - IDLE with `start`=1 and a non-MUL op: compute, register, pulse `done`, stay in IDLE.
  - IDLE with `start`=1 and MUL: capture operands, enter MUL, raise `busy`.
  - MUL after WIDTH iterations: register the result, pulse `done`, return to IDLE.
- Opcodes:
  - 000 ADD: `carry` = carry-out; `overflow` = signed add overflow.
  - 001 SUB (A-B): `carry` = borrow (A<B unsigned); `overflow` = signed sub overflow.
  - 010 AND, 011 OR, 100 XOR: `carry` = 0, `overflow` = 0.
  - 101 SHL and 110 SHR (logical): shift amount is `inB[$clog2(WIDTH)-1:0]`. `carry` = last bit shifted out, or 0 for amount 0. `overflow` = 0.
  - 111 MUL (unsigned): `out` = low WIDTH bits of A*B. `carry` = `overflow` = OR of the high WIDTH product bits.
- All arithmetic is modulo 2^WIDTH. `isZero` and `negative` always derive from the registered `out`.
- `start` while `busy`=1 is ignored. No queuing; the operation in flight is unaffected.
- `start` in the same cycle as `done` is legal, because the FSM is already in IDLE.
- Operands are captured at acceptance. Input changes afterwards have no effect on the operation in flight.
- Reset asserted mid-MUL aborts immediately: all outputs return to reset values and no `done` is issued.

## Timing
- Non-MUL ops: `start` sampled at edge N; `out`, flags and `done`=1 visible after edge N; `done` clears after edge N+1 unless a new op is accepted.
- MUL: accepted at edge N, so `busy`=1 after edge N. One partial product per edge, N+1..N+WIDTH. `done`=1 and `busy`=0 after edge N+WIDTH.
- Back-to-back non-MUL ops give one result per cycle.
- No combinational path from inputs to outputs.

## Configuration
- `ALU_MUL_EN` defined:
  - opcode 111 runs the iterative multiplier as specified above.
- `ALU_MUL_EN` undefined:
  - no multiplier logic is built; `busy` is tied 0.
  - opcode 111 is illegal: it completes in one cycle like the other ops, with `out`=0, `isZero`=1 and all other flags 0.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams `ALU_ADD`..`ALU_MUL`;
  - the FSM state typedef `alu_state_t` (IDLE, MUL);
  - the flag-vector typedef.
- Sub-module `alu_mul_iter`: shift-add unsigned multiplier with `load`, `WIDTH`-cycle counter and a 2*WIDTH-bit product. It is instantiated only under `ALU_MUL_EN`.
- Flag generation and the single-cycle ops stay in `alu_seq`.

## Test plan
(WIDTH=8 unless noted.)
- ADD 10+20; SUB 30-30 → `out`=30 then 0; `isZero`=0 then 1; `carry`=0; `done` one cycle after each `start`.
- ADD 200+100 → `out`=44, `carry`=1. ADD 100+50 → `out`=150, `overflow`=1, `negative`=1. SUB 5-7 → `out`=254, `carry`=1.
- AND/OR/XOR on 0xCC, 0xAA → 0x88 / 0xEE / 0x66, `carry`=0. SHL 0x81 by 1 → 0x02, `carry`=1. SHR 0x81 by 0 → 0x81, `carry`=0.
- MUL 15*17 → `out`=255, `carry`=0, `done` exactly 8 cycles after acceptance. MUL 16*16 → `out`=0, `isZero`=1, `carry`=`overflow`=1. A `start` during `busy` with ADD 1+1 → ignored; the MUL result is unchanged.
- `rst_n` pulsed low during MUL iteration 4 → outputs at reset values at once, no `done`. The next ADD 1+2 → 3 normally.
- Build without `ALU_MUL_EN`: opcode 111 → `done` after 1 cycle, `out`=0, `isZero`=1, `busy` never asserted. Rerun ADD 200+100 with WIDTH=16 → `out`=300, `carry`=0.
